// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst reader: FSM encoding, skid depth
// and the pointer helper used by the skid buffer.
package fifo_burst_reader_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Three entries cover the pop-to-capture latency at one word per cycle.
  localparam int SKID_DEPTH = 3;

  typedef logic [1:0] skid_idx_t;

  // Circular increment over the SKID_DEPTH entries.
  function automatic skid_idx_t skid_next(input skid_idx_t p);
    return (p == skid_idx_t'(SKID_DEPTH - 1)) ? skid_idx_t'(0) : p + skid_idx_t'(1);
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Small register FIFO that absorbs words already popped from the RAM FIFO
// while the downstream consumer stalls. Push and pop may coincide.
module fifo_skid_buf
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            occ
);

  logic [SKID_DEPTH-1:0][DATA_WIDTH-1:0] entries;
  skid_idx_t wr_ptr_reg;
  skid_idx_t rd_ptr_reg;
  logic [1:0] occ_reg;

  // One storage register per entry, loaded when the write pointer selects it.
  generate
    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : gen_entry
      logic [DATA_WIDTH-1:0] entry_reg;

      // Capture the incoming word into this slot.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == skid_idx_t'(gi))) begin
          entry_reg <= push_data;
        end
      end

      assign entries[gi] = entry_reg;
    end
  endgenerate

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves occ unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= skid_next(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= skid_next(rd_ptr_reg);
      end
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + 2'd1;
        2'b01:   occ_reg <= occ_reg - 2'd1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  assign head_data = entries[rd_ptr_reg];
  assign occ       = occ_reg;

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst drain engine: pops exactly BURST_LEN words from the read port of the
// dual-clock FIFO and replays them as a valid/ready stream with a last marker.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16
) (
  input  logic                  r_clk,
  input  logic                  rst,
  input  logic                  burst_req,
  output logic                  burst_busy,
  output logic                  burst_done,
  input  logic                  r_empty,
  output logic                  r_pop,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] LEN_CNT  = CW'(BURST_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

  logic [0:0]    state_reg;
  logic [CW-1:0] pop_cnt_reg;
  logic [CW-1:0] out_cnt_reg;
  logic          inflight_reg;
  logic          done_reg;
  logic [1:0]    occ;
  logic          in_burst;
  logic          credit_ok;
  logic          handshake;
  logic          start_burst;

  assign in_burst    = (state_reg == ST_BURST);
  assign start_burst = (state_reg == ST_IDLE) && burst_req;

  // Words buffered plus the one still coming out of RAM must leave a free slot,
  // so a pop is never issued without room to land it.
  assign credit_ok = ({1'b0, occ} + {2'b00, inflight_reg}) < 3'(SKID_DEPTH);

  // Pop decision uses only registered state and r_empty, never m_ready.
  assign r_pop = in_burst && !r_empty && (pop_cnt_reg < LEN_CNT) && credit_ok;

  assign m_valid   = (occ != 2'd0);
  assign m_last    = m_valid && (out_cnt_reg == LAST_CNT);
  assign handshake = m_valid && m_ready;

  // Burst FSM: leave BURST after the last word is accepted.
  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  if (burst_req) state_reg <= ST_BURST;
        ST_BURST: if (handshake && m_last) state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  // Pop and output counters; both restart at the beginning of every burst.
  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      pop_cnt_reg <= '0;
      out_cnt_reg <= '0;
    end else if (start_burst) begin
      pop_cnt_reg <= '0;
      out_cnt_reg <= '0;
    end else begin
      if (r_pop) begin
        pop_cnt_reg <= pop_cnt_reg + CW'(1);
      end
      if (handshake) begin
        out_cnt_reg <= out_cnt_reg + CW'(1);
      end
    end
  end

  // Track the RAM read latency and generate the end-of-burst pulse.
  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      inflight_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      inflight_reg <= r_pop;
      done_reg     <= in_burst && handshake && m_last;
    end
  end

  fifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (r_clk),
    .rst      (rst),
    .push     (inflight_reg),
    .push_data(r_data),
    .pop      (handshake),
    .head_data(m_data),
    .occ      (occ)
  );

  assign burst_busy = in_burst;
  assign burst_done = done_reg;

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side drain engine for the dual-clock FIFO. On a burst request it pops exactly BURST_LEN words through the FIFO's pop/empty interface, absorbs the one-cycle RAM read latency, and presents the words as a registered valid/ready stream with a last-word marker. It sits entirely in the read clock domain, between the FIFO read port and a downstream consumer.

## Interface
- DATA_WIDTH, 32, width of FIFO words and stream data
- BURST_LEN, 16, words per burst, ≥1; counters are $clog2(BURST_LEN+1) bits
- r_clk  in  1  read-domain clock, rising edge
- rst  in  1  reset; one clock, asynchronous, active-high
- burst_req  in  1  start request, sampled in IDLE only
- burst_busy  out  1  high while state is BURST
- burst_done  out  1  one-cycle pulse after the final word handshakes
- r_empty  in  1  FIFO empty flag
- r_pop  out  1  FIFO pop; word appears on r_data the following cycle
- r_data  in  DATA_WIDTH  FIFO read data
- m_valid  out  1  stream word valid
- m_ready  in  1  consumer accepts
- m_data  out  DATA_WIDTH  stream data
- m_last  out  1  high with the BURST_LEN-th word of the burst

## Operation
- FSM: IDLE → BURST on burst_req; BURST → IDLE on the edge after the handshake where m_last is high. burst_req in BURST, including the final cycle, is ignored.
- Skid buffer: 3-entry FIFO of registers, with occupancy count occ (0..3) and an inflight flag (pop issued last cycle).
- r_pop = BURST & !r_empty & pop_cnt < BURST_LEN & (occ + inflight) < 3. It depends only on registered state plus r_empty, and never on m_ready.
- Word arrival: on the edge after a pop, r_data is written into the buffer and occ increments. A simultaneous handshake decrements occ, and both may occur on the same edge.
- Credit freed by a handshake becomes usable the following cycle. Capacity 3 sustains one word per cycle.
- m_valid = occ != 0. m_data is the buffer head. m_last = m_valid & (out_cnt == BURST_LEN-1).
- pop_cnt increments per pop and out_cnt per handshake. Both clear when entering BURST.
- r_empty high mid-burst: pops pause and resume when it drops. The burst never ends early.
- Backpressure: m_data and m_last are held stable while m_valid & !m_ready.
- BURST_LEN=1: a single pop, and m_last rides with the first word.
- Reset values (asynchronous, immediate): state IDLE, occ 0, inflight 0, counters 0. Outputs r_pop, m_valid, m_last, burst_busy and burst_done are all 0, and m_data is 0.
- Reset mid-burst: the inflight word and buffered words are discarded. FIFO contents are not restored.

## Timing
- burst_req high in cycle 0 → burst_busy and the first r_pop in cycle 1 → word in buffer, m_valid in cycle 3.
- Pop-to-m_valid latency: 2 cycles.
- With m_ready held high and the FIFO non-empty: pops in cycles 1..BURST_LEN, m_valid in cycles 3..BURST_LEN+2, burst_done in cycle BURST_LEN+3.
- burst_busy falls in the same cycle that burst_done pulses. A new burst_req is accepted in that cycle.

## Structure
- Shared package: FSM state encoding (IDLE, BURST) and the skid-buffer depth constant (3).
- One sub-module, fifo_skid_buf: 3-entry register buffer with push/pop/occ. The FSM, counters and pop/credit logic stay in the top.

## Test plan
- Reset: assert rst mid-cycle with burst_req high → all outputs 0 immediately, and they stay 0 until a burst_req after release.
- BURST_LEN=4, FIFO preloaded with 0xA0..0xA3, m_ready=1, burst_req in cycle 0:
  - r_pop in cycles 1–4.
  - m_valid in cycles 3–6 with data 0xA0..0xA3.
  - m_last in cycle 6.
  - burst_done in cycle 7.
  - burst_busy in cycles 1–6.
- Same burst with m_ready=0 from cycle 0:
  - exactly 3 pops, then r_pop stays low.
  - m_data holds 0xA0.
  - after m_ready rises, the remaining words arrive in order and the 4th pop is issued.
- r_empty high in cycles 2–5 with 1 word preloaded and 3 written later → 1 pop, a stall, then resumption. Total 4 handshakes, last=0xA3 with m_last, no extra pop.
- rst asserted in cycle 4 of a BURST_LEN=8 burst → r_pop and m_valid drop immediately. A post-reset burst_req starts a fresh 8-word burst with pop_cnt and out_cnt from 0.
- burst_req held high continuously, BURST_LEN=2:
  - exactly 2 pops per burst.
  - bursts are back-to-back, the next starting in the burst_done cycle.
  - no request is honoured while burst_busy is high.
